oh_memory_ram_pipe: RTL and testbench

Single-clock, dual-port (one read, one write) generic RAM with bit-granular write mask, configurable read latency, selectable read-during-write behaviour and an optional post-reset clear engine. Drop-in storage for FIFOs, retry buffers and lookup tables in the AXI/eMesh bridge, where a result-valid strobe and known post-reset contents are required.

---
 rtl/oh_memory_pkg.sv | 20 ++
 rtl/oh_memory_ram_clr.sv | 65 ++++++
 rtl/oh_memory_ram_pipe.sv | 157 +++++++++++++++
 tb/tb_oh_memory_ram_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oh_memory_pkg.sv
// oh_memory_pkg
// Shared definitions for the oh_memory RAM family.
//   RDW_OLD / RDW_NEW     read-during-write modes (old data / write-first merge)
//   RDLAT_MIN / RDLAT_MAX legal range of read pipeline latency
//   clr_state_t           post-reset clear engine states
package oh_memory_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 4;

  typedef enum logic [1:0] {
    CLR_RESET = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_RUN   = 2'd2
  } clr_state_t;

endpackage

// File: rtl/oh_memory_ram_clr.sv
// oh_memory_ram_clr
// Post-reset clear engine: walks every address once after nreset release so
// the RAM holds a known word before the ports are opened. It is only
// instantiated when OH_RAM_CLEAR_EN is defined.
// Ports:
//   clk       in   clock
//   nreset    in   synchronous active-low reset; restarts the walk at address 0
//   clr_we    out  clear write strobe (full mask, INITVAL data in the parent)
//   clr_addr  out  address being cleared
//   busy      out  clear in progress; the parent blocks its ports while high
module oh_memory_ram_clr
  import oh_memory_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          nreset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_t    state;
  logic [AW-1:0] count;

  // Reset parks the engine in CLEAR at address 0 so the walk starts on the
  // first edge after release and ends DEPTH edges later.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= CLR_CLEAR;
      count <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLR_CLEAR: begin
          if (count == LAST_ADDR) begin
            state <= CLR_RUN;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            count <= count + AW'(1);
          end
        end
        CLR_RUN: begin
          state <= CLR_RUN;
          busy  <= 1'b0;
        end
        default: begin
          state <= CLR_CLEAR;
          count <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // busy is high during reset too; the address-0 writes this causes are
  // redone by the walk itself, so no extra gating is needed.
  assign clr_we   = busy;
  assign clr_addr = count;

endmodule

// File: rtl/oh_memory_ram_pipe.sv
// oh_memory_ram_pipe
// Single-clock RAM with one read and one write port, per-bit write mask,
// RDLAT-cycle registered read path with a result-valid strobe, selectable
// read-during-write behaviour and an optional post-reset clear engine
// (compile with OH_RAM_CLEAR_EN defined to include it).
// Ports:
//   clk        in   clock for both ports
//   nreset     in   synchronous active-low reset; flushes in-flight reads
//   rd_en      in   read request
//   rd_addr    in   read address (>= DEPTH reads back zero)
//   rd_dout    out  read data, updated only when a result arrives
//   rd_valid   out  one-cycle strobe, RDLAT cycles after the read was sampled
//   wr_en      in   write request
//   wr_addr    in   write address (>= DEPTH is dropped)
//   wr_wem     in   per-bit write enable
//   wr_din     in   write data
//   init_busy  out  clear engine running; port requests are ignored
module oh_memory_ram_pipe
  import oh_memory_pkg::*;
#(
  parameter int             DW      = 104,
  parameter int             DEPTH   = 32,
  parameter int             AW      = $clog2(DEPTH),
  parameter int             RDLAT   = 1,
  parameter int             RDW     = RDW_OLD,
  parameter logic [DW-1:0]  INITVAL = {DW{1'b0}}
)(
  input  logic          clk,
  input  logic          nreset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dout,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_wem,
  input  logic [DW-1:0] wr_din,
  output logic          init_busy
);

  if (RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX) begin : g_bad_rdlat
    $error("oh_memory_ram_pipe: RDLAT must lie in 1..4");
  end

  // One extra address bit so the range check also works when DEPTH is a
  // power of two.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef OH_RAM_CLEAR_EN
  oh_memory_ram_clr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .clk      (clk),
    .nreset   (nreset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (init_busy)
  );
`else
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign init_busy = 1'b0;
`endif

  logic wr_in_range;
  logic rd_in_range;
  logic port_wr;
  logic port_rd;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
  assign port_wr     = wr_en & ~init_busy & wr_in_range;
  assign port_rd     = rd_en & ~init_busy;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata;

  // The clear engine owns the write port while it runs.
  always_comb begin
    mem_we    = port_wr;
    mem_waddr = wr_addr;
    mem_wmask = wr_wem;
    mem_wdata = wr_din;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wmask = {DW{1'b1}};
      mem_wdata = INITVAL;
    end
  end

  logic [DW-1:0] mem [DEPTH];

  // Storage: bit-granular masked write, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  logic [DW-1:0] rd_old;
  logic [DW-1:0] rd_word;

  // Word entering stage 1. With write-first mode a same-address write in the
  // same cycle is merged through its mask so the read sees the new bits.
  always_comb begin
    rd_old = '0;
    if (rd_in_range) begin
      rd_old = mem[rd_addr];
    end
    rd_word = rd_old;
    if (RDW == RDW_NEW && port_wr && wr_addr == rd_addr) begin
      rd_word = (wr_din & wr_wem) | (rd_old & ~wr_wem);
    end
  end

  logic [DW-1:0]    pipe_data [RDLAT];
  logic [RDLAT-1:0] pipe_valid;

  // Valid bits and the output register are reset; this is what drops any
  // read still in flight when nreset is asserted.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pipe_valid <= '0;
      rd_valid   <= 1'b0;
      rd_dout    <= '0;
    end else begin
      pipe_valid[0] <= port_rd;
      for (int i = 1; i < RDLAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      rd_valid <= pipe_valid[RDLAT-1];
      if (pipe_valid[RDLAT-1]) begin
        rd_dout <= pipe_data[RDLAT-1];
      end
    end
  end

  // Data stages carry no reset and only move when their valid bit is set.
  always_ff @(posedge clk) begin
    if (port_rd) begin
      pipe_data[0] <= rd_word;
    end
    for (int i = 1; i < RDLAT; i++) begin
      if (pipe_valid[i-1]) begin
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_oh_memory_ram_pipe.sv
// tb_oh_memory_ram_pipe
// Drives two RAM instances from the same inputs:
//   dut_a: DEPTH=32, RDLAT=3, old-data read-during-write
//   dut_b: DEPTH=24, RDLAT=4, write-first read-during-write
// Both use AW=5, so addresses 24..31 are out of range only for dut_b.
// Clear-engine sequences are included when OH_RAM_CLEAR_EN is defined.
module tb_oh_memory_ram_pipe;
  import oh_memory_pkg::*;

  localparam int DW = 104;
  localparam int AW = 5;
  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 24;
  localparam logic [DW-1:0] INIT = {13{8'hA5}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          nreset;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wem;
  logic [DW-1:0] wr_din;
  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b;
  logic          busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wem;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Free-running clock.
  always #5 clk = ~clk;

  oh_memory_ram_pipe #(
    .DW(DW), .DEPTH(DEPTH_A), .AW(AW), .RDLAT(3), .RDW(RDW_OLD), .INITVAL(INIT)
  ) dut_a (
    .clk(clk), .nreset(nreset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(dout_a), .rd_valid(valid_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_wem(wr_wem), .wr_din(wr_din), .init_busy(busy_a)
  );

  oh_memory_ram_pipe #(
    .DW(DW), .DEPTH(DEPTH_B), .AW(AW), .RDLAT(4), .RDW(RDW_NEW), .INITVAL(INIT)
  ) dut_b (
    .clk(clk), .nreset(nreset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(dout_b), .rd_valid(valid_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_wem(wr_wem), .wr_din(wr_din), .init_busy(busy_b)
  );

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wem, input logic [DW-1:0] din,
                              input logic re, input logic [AW-1:0] ra,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wem = wem; v.din = din;
    v.rd_en = re; v.rd_addr = ra; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  function automatic logic [DW-1:0] pattern(input int i);
    return {8'(i + 1), 88'h0, 8'(~i)};
  endfunction

  // Expected sweep word: mode 0 = cleared contents, mode 1 = burst pattern.
  function automatic logic [DW-1:0] sweepExp(input int mode, input int depth, input int j);
    if (j >= depth) return '0;
    return (mode == 0) ? INIT : pattern(j);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Starts at a negedge: one cycle of the vector, then four cycles of idle
  // during which each DUT must show exactly one valid at its own latency.
  task automatic applyStimulus(input vec_t v, input int idx);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_wem = v.wem; wr_din = v.din;
    rd_en = v.rd_en; rd_addr = v.rd_addr;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid_a k%0d", idx, k), DW'(valid_a), DW'(v.rd_en && k == 3));
      checkOutput($sformatf("vec%0d valid_b k%0d", idx, k), DW'(valid_b), DW'(v.rd_en && k == 4));
      if (v.rd_en && k == 3) checkOutput($sformatf("vec%0d dout_a", idx), dout_a, v.exp_a);
      if (v.rd_en && k == 4) checkOutput($sformatf("vec%0d dout_b", idx), dout_b, v.exp_b);
    end
  endtask

  // Back-to-back reads of addresses 0..31, one per cycle, checking every
  // cycle that results arrive in order at each DUT's latency.
  task automatic runSweep(input int mode);
    int ja, jb;
    for (int c = 0; c <= 37; c++) begin
      ja = c - 4;
      jb = c - 5;
      checkOutput($sformatf("sweep%0d valid_a c%0d", mode, c), DW'(valid_a), DW'(ja >= 0 && ja < 32));
      checkOutput($sformatf("sweep%0d valid_b c%0d", mode, c), DW'(valid_b), DW'(jb >= 0 && jb < 32));
      if (ja >= 0 && ja < 32) checkOutput($sformatf("sweep%0d dout_a addr%0d", mode, ja), dout_a, sweepExp(mode, DEPTH_A, ja));
      if (jb >= 0 && jb < 32) checkOutput($sformatf("sweep%0d dout_b addr%0d", mode, jb), dout_b, sweepExp(mode, DEPTH_B, jb));
      wr_en   = 1'b0;
      rd_en   = (c < 32);
      rd_addr = AW'(c);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

`ifdef OH_RAM_CLEAR_EN
  // Called at the negedge where nreset is released. Counts busy cycles and
  // optionally hammers both ports while both DUTs are still clearing.
  task automatic countBusy(input bit drive_ports);
    int cnt_a, cnt_b;
    bit seen_valid;
    cnt_a = 0; cnt_b = 0; seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (valid_a || valid_b) seen_valid = 1'b1;
      if (drive_ports && k < 20) begin
        rd_en = 1'b1; rd_addr = AW'(k);
        wr_en = 1'b1; wr_addr = AW'(2); wr_din = '0; wr_wem = ONES;
      end else begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("clear busy cycles a", DW'(cnt_a), DW'(DEPTH_A));
    checkOutput("clear busy cycles b", DW'(cnt_b), DW'(DEPTH_B));
    checkOutput("clear no valid", DW'(seen_valid), DW'(0));
  endtask
`endif

  initial begin
    bit seen;

    vecs[0]  = mk(1'b1, 5'd5,  ONES,          104'h1234, 1'b0, 5'd0,  '0,          '0);
    vecs[1]  = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd5,  104'h1234,   104'h1234);
    vecs[2]  = mk(1'b1, 5'd7,  ONES,          ONES,      1'b0, 5'd0,  '0,          '0);
    vecs[3]  = mk(1'b1, 5'd7,  104'hF,        '0,        1'b0, 5'd0,  '0,          '0);
    vecs[4]  = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd7,  ~104'hF,     ~104'hF);
    vecs[5]  = mk(1'b1, 5'd3,  ONES,          104'h00FF, 1'b0, 5'd0,  '0,          '0);
    vecs[6]  = mk(1'b1, 5'd3,  ONES,          104'hFF00, 1'b1, 5'd3,  104'h00FF,   104'hFF00);
    vecs[7]  = mk(1'b1, 5'd3,  ONES,          104'h00FF, 1'b0, 5'd0,  '0,          '0);
    vecs[8]  = mk(1'b1, 5'd3,  104'hF000,     104'hFF00, 1'b1, 5'd3,  104'h00FF,   104'hF0FF);
    vecs[9]  = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd3,  104'hF0FF,   104'hF0FF);
    vecs[10] = mk(1'b1, 5'd30, ONES,          104'hDEAD, 1'b0, 5'd0,  '0,          '0);
    vecs[11] = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd30, 104'hDEAD,   '0);
    vecs[12] = mk(1'b1, 5'd0,  ONES,          104'hBEEF, 1'b1, 5'd5,  104'h1234,   104'h1234);
    vecs[13] = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd0,  104'hBEEF,   104'hBEEF);
    vecs[14] = mk(1'b1, 5'd5,  '0,            '0,        1'b1, 5'd7,  ~104'hF,     ~104'hF);
    vecs[15] = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd5,  104'h1234,   104'h1234);
    vecs[16] = mk(1'b1, 5'd23, ONES,          104'h77,   1'b0, 5'd0,  '0,          '0);
    vecs[17] = mk(1'b0, 5'd0,  '0,            '0,        1'b1, 5'd23, 104'h77,     104'h77);

    nreset = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_wem = '0; wr_din = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset dout_a", dout_a, '0);
    checkOutput("reset dout_b", dout_b, '0);
    checkOutput("reset valid_a", DW'(valid_a), DW'(0));
    checkOutput("reset valid_b", DW'(valid_b), DW'(0));
`ifdef OH_RAM_CLEAR_EN
    checkOutput("reset busy_a", DW'(busy_a), DW'(1));
    checkOutput("reset busy_b", DW'(busy_b), DW'(1));
    nreset = 1'b1;
    $display("[TB] clear engine after reset");
    countBusy(1'b1);
    runSweep(0);
`else
    checkOutput("reset busy_a", DW'(busy_a), DW'(0));
    checkOutput("reset busy_b", DW'(busy_b), DW'(0));
    nreset = 1'b1;
    @(negedge clk);
`endif

    $display("[TB] burst write then back-to-back reads");
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = AW'(31 - i); wr_wem = ONES; wr_din = pattern(31 - i);
      @(negedge clk);
    end
    runSweep(1);

    $display("[TB] directed vectors");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] reset with reads in flight");
    seen = 1'b0;
    rd_en = 1'b1; rd_addr = AW'(1);
    @(negedge clk);
    rd_addr = AW'(2);
    @(negedge clk);
    rd_addr = AW'(3);
    @(negedge clk);
    rd_en = 1'b0; nreset = 1'b0;
    @(negedge clk);
    checkOutput("midreset dout_a", dout_a, '0);
    checkOutput("midreset dout_b", dout_b, '0);
`ifdef OH_RAM_CLEAR_EN
    checkOutput("midreset busy_a", DW'(busy_a), DW'(1));
    checkOutput("midreset busy_b", DW'(busy_b), DW'(1));
`endif
    nreset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (valid_a || valid_b) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("midreset no valid", DW'(seen), DW'(0));

`ifdef OH_RAM_CLEAR_EN
    $display("[TB] reset during clear restarts at address 0");
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    countBusy(1'b0);
    runSweep(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
